flex_pts_tx_ctrl: RTL

- Transmit sequencer for a flex parallel-to-serial shift register that shifts MSB first and shifts in 1s.
- Accepts a data word over a valid/ready handshake and builds a frame: start bit 0, data MSB first, stop bit 1.
- Drives the shift register's parallel input, load_enable and shift_enable so that each frame bit is held on serial_out for a programmable number of clocks.
- Sits between the transmit datapath and a shift register of width NUM_BITS+2.

---
 rtl/flex_pts_tx_ctrl_if.sv | 21 ++
 rtl/flex_pts_tx_ctrl.sv | 100 ++++++++++
 2 files changed

// File: rtl/flex_pts_tx_ctrl_if.sv
// Transmit word handshake between the datapath and flex_pts_tx_ctrl.
// The datapath is the master; the controller is the slave.
interface flex_pts_tx_ctrl_if #(
   parameter int NUM_BITS = 8
);
   logic [NUM_BITS-1:0] tx_data;
   logic                tx_valid;
   logic                tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );
endinterface

// File: rtl/flex_pts_tx_ctrl.sv
// Transmit sequencer for an MSB-first, 1-filling parallel-to-serial shifter.
// Frames are {start 0, data MSB first, stop 1}, each bit held CLKS_PER_BIT clocks.
module flex_pts_tx_ctrl #(
   parameter int NUM_BITS     = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic                clk,
   input  logic                rst,
   flex_pts_tx_ctrl_if.slave   tx,
   output logic [NUM_BITS+1:0] parallel_out,
   output logic                load_enable,
   output logic                shift_enable,
   output logic                busy,
   output logic                frame_done
);
   localparam int FRAME = NUM_BITS + 2;
   localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW    = $clog2(FRAME + 1);

   localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(FRAME - 1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT
   } state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     clk_cnt_q, clk_cnt_d;
   logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [FRAME-1:0]  par_q, par_d;
   logic              last_clk;
   logic              last_bit;

   assign last_clk = (clk_cnt_q == CLK_LAST);
   assign last_bit = (bit_cnt_q == BIT_LAST);

   // Next-state, counter and output decode; outputs depend on registers only.
   always_comb begin
      state_d      = state_q;
      clk_cnt_d    = clk_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      par_d        = par_q;
      load_enable  = 1'b0;
      shift_enable = 1'b0;
      busy         = 1'b0;
      frame_done   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (tx.tx_valid) begin
               par_d   = {1'b0, tx.tx_data, 1'b1};
               state_d = LOAD;
            end
         end
         LOAD: begin
            load_enable = 1'b1;
            busy        = 1'b1;
            clk_cnt_d   = '0;
            bit_cnt_d   = '0;
            state_d     = SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            if (last_clk) begin
               shift_enable = 1'b1;
               clk_cnt_d    = '0;
               bit_cnt_d    = bit_cnt_q + 1'b1;
               if (last_bit) begin
                  frame_done = 1'b1;
                  state_d    = IDLE;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, counters and frame register; reset aborts any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         clk_cnt_q <= '0;
         bit_cnt_q <= '0;
         par_q     <= '1;
      end else begin
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         par_q     <= par_d;
      end
   end

   assign parallel_out = par_q;
   assign tx.tx_ready  = (state_q == IDLE) & ~rst;
endmodule
